// File: rtl/matvec_job_ctrl.sv
// Job sequencer for mat_vec_mult: resets the datapath, fetches B and the columns of A over a
// word-wide read port, fills the FIFOs, launches compute and latches the MAC results.
module matvec_job_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_MACS   = 8,
    parameter int VEC_LEN    = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     go,
    input  logic [ADDR_WIDTH-1:0]                    base_a,
    input  logic [ADDR_WIDTH-1:0]                    base_b,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     err,
    output logic [ADDR_WIDTH-1:0]                    mem_address,
    output logic                                     mem_read,
    input  logic                                     mem_waitrequest,
    input  logic [NUM_MACS*DATA_WIDTH-1:0]           mem_readdata,
    input  logic                                     mem_readdatavalid,
    output logic                                     dp_rst_n,
    output logic                                     clr_accum,
    output logic                                     start_compute,
    output logic [NUM_MACS-1:0][DATA_WIDTH-1:0]      fifo_a_data,
    output logic [NUM_MACS-1:0]                      fifo_a_wren,
    input  logic [NUM_MACS-1:0]                      fifo_a_full,
    output logic [DATA_WIDTH-1:0]                    fifo_b_data,
    output logic                                     fifo_b_wren,
    input  logic                                     fifo_b_full,
    input  logic                                     all_fifos_full,
    input  logic                                     compute_done,
    input  logic [NUM_MACS-1:0][3*DATA_WIDTH-1:0]    mac_out,
    output logic [NUM_MACS-1:0][3*DATA_WIDTH-1:0]    res_out
);

    localparam int KW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(VEC_LEN - 1);
    localparam logic [KW-1:0] K_ONE  = KW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DP_RST = 3'd1,
        S_RD_B   = 3'd2,
        S_RD_A   = 3'd3,
        S_LAUNCH = 3'd4,
        S_WAIT   = 3'd5,
        S_FINISH = 3'd6
    } state_t;

    state_t                                  state_r, state_s;
    logic [KW-1:0]                           k_r, k_s, k_inc_s;
    logic [ADDR_WIDTH-1:0]                   base_a_r, base_a_s, base_b_r, base_b_s;
    logic [NUM_MACS-1:0][DATA_WIDTH-1:0]     b_word_r, b_word_s;
    logic [ADDR_WIDTH-1:0]                   mem_address_r, mem_address_s;
    logic                                    mem_read_r, mem_read_s;
    logic                                    busy_r, busy_s, done_r, done_s, err_r, err_s;
    logic                                    dp_rst_n_r, dp_rst_n_s, clr_accum_r, clr_accum_s;
    logic                                    start_r, start_s;
    logic [NUM_MACS-1:0][DATA_WIDTH-1:0]     fifo_a_data_r, fifo_a_data_s;
    logic [NUM_MACS-1:0]                     fifo_a_wren_r, fifo_a_wren_s;
    logic [DATA_WIDTH-1:0]                   fifo_b_data_r, fifo_b_data_s;
    logic                                    fifo_b_wren_r, fifo_b_wren_s;
    logic [NUM_MACS-1:0][3*DATA_WIDTH-1:0]   res_r, res_s;
    logic                                    accepted_s, rdata_s, any_full_s;

    // Next-state and next-output decode; every output is registered from these values.
    always_comb begin
        state_s       = state_r;
        k_s           = k_r;
        base_a_s      = base_a_r;
        base_b_s      = base_b_r;
        b_word_s      = b_word_r;
        mem_address_s = mem_address_r;
        mem_read_s    = mem_read_r;
        err_s         = err_r;
        done_s        = 1'b0;
        dp_rst_n_s    = 1'b1;
        clr_accum_s   = 1'b0;
        start_s       = 1'b0;
        fifo_a_data_s = fifo_a_data_r;
        fifo_a_wren_s = {NUM_MACS{1'b0}};
        fifo_b_data_s = fifo_b_data_r;
        fifo_b_wren_s = 1'b0;
        res_s         = res_r;
        k_inc_s       = k_r + K_ONE;
        // A request still on the bus cannot also be returning data, so this keeps one read in flight.
        accepted_s    = mem_read_r & ~mem_waitrequest;
        rdata_s       = mem_readdatavalid & ~mem_read_r;
        any_full_s    = (|fifo_a_full) | fifo_b_full;

        case (state_r)
            S_IDLE: begin
                if (go) begin
                    state_s     = S_DP_RST;
                    err_s       = 1'b0;
                    base_a_s    = base_a;
                    base_b_s    = base_b;
                    k_s         = {KW{1'b0}};
                    dp_rst_n_s  = 1'b0;
                    clr_accum_s = 1'b1;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_DP_RST: begin
                state_s       = S_RD_B;
                mem_read_s    = 1'b1;
                mem_address_s = base_b_r;
            end
            S_RD_B: begin
                if (accepted_s) begin
                    mem_read_s = 1'b0;
                end else begin
                    mem_read_s = mem_read_r;
                end
                if (rdata_s) begin
                    b_word_s      = mem_readdata;
                    state_s       = S_RD_A;
                    mem_read_s    = 1'b1;
                    mem_address_s = base_a_r + ADDR_WIDTH'(k_r);
                end else begin
                    state_s = S_RD_B;
                end
            end
            S_RD_A: begin
                if (accepted_s) begin
                    mem_read_s = 1'b0;
                end else begin
                    mem_read_s = mem_read_r;
                end
                if (rdata_s && any_full_s) begin
                    err_s   = 1'b1;
                    done_s  = 1'b1;
                    state_s = S_FINISH;
                end else if (rdata_s) begin
                    fifo_a_wren_s = {NUM_MACS{1'b1}};
                    fifo_a_data_s = mem_readdata;
                    fifo_b_wren_s = 1'b1;
                    fifo_b_data_s = b_word_r[k_r];
                    if (k_r == K_LAST) begin
                        state_s = S_LAUNCH;
                    end else begin
                        k_s           = k_inc_s;
                        mem_read_s    = 1'b1;
                        mem_address_s = base_a_r + ADDR_WIDTH'(k_inc_s);
                    end
                end else begin
                    state_s = S_RD_A;
                end
            end
            S_LAUNCH: begin
                if (all_fifos_full) begin
                    start_s = 1'b1;
                    state_s = S_WAIT;
                end else begin
                    state_s = S_LAUNCH;
                end
            end
            S_WAIT: begin
                if (compute_done) begin
                    res_s   = mac_out;
                    done_s  = 1'b1;
                    state_s = S_FINISH;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_FINISH: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase

        busy_s = (state_s != S_IDLE);
    end

    // State and output registers; reset parks the datapath in reset with everything idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            k_r           <= {KW{1'b0}};
            base_a_r      <= {ADDR_WIDTH{1'b0}};
            base_b_r      <= {ADDR_WIDTH{1'b0}};
            b_word_r      <= {(NUM_MACS*DATA_WIDTH){1'b0}};
            mem_address_r <= {ADDR_WIDTH{1'b0}};
            mem_read_r    <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
            dp_rst_n_r    <= 1'b0;
            clr_accum_r   <= 1'b0;
            start_r       <= 1'b0;
            fifo_a_data_r <= {(NUM_MACS*DATA_WIDTH){1'b0}};
            fifo_a_wren_r <= {NUM_MACS{1'b0}};
            fifo_b_data_r <= {DATA_WIDTH{1'b0}};
            fifo_b_wren_r <= 1'b0;
            res_r         <= {(NUM_MACS*3*DATA_WIDTH){1'b0}};
        end else begin
            state_r       <= state_s;
            k_r           <= k_s;
            base_a_r      <= base_a_s;
            base_b_r      <= base_b_s;
            b_word_r      <= b_word_s;
            mem_address_r <= mem_address_s;
            mem_read_r    <= mem_read_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
            err_r         <= err_s;
            dp_rst_n_r    <= dp_rst_n_s;
            clr_accum_r   <= clr_accum_s;
            start_r       <= start_s;
            fifo_a_data_r <= fifo_a_data_s;
            fifo_a_wren_r <= fifo_a_wren_s;
            fifo_b_data_r <= fifo_b_data_s;
            fifo_b_wren_r <= fifo_b_wren_s;
            res_r         <= res_s;
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign err           = err_r;
    assign mem_address   = mem_address_r;
    assign mem_read      = mem_read_r;
    assign dp_rst_n      = dp_rst_n_r;
    assign clr_accum     = clr_accum_r;
    assign start_compute = start_r;
    assign fifo_a_data   = fifo_a_data_r;
    assign fifo_a_wren   = fifo_a_wren_r;
    assign fifo_b_data   = fifo_b_data_r;
    assign fifo_b_wren   = fifo_b_wren_r;
    assign res_out       = res_r;

endmodule

// File: tb/tb_matvec_job_ctrl.sv
// Randomized bench for matvec_job_ctrl: memory and datapath models plus a scoreboard whose
// expected results come from a plain matrix-vector product over the memory image.
module tb_matvec_job_ctrl;

    localparam int DW = 8;
    localparam int NM = 8;
    localparam int VL = 8;
    localparam int AW = 32;
    localparam int RW = 3 * DW;

    logic                     clk;
    logic                     rst_n;
    logic                     go;
    logic [AW-1:0]            base_a, base_b;
    logic                     busy, done, err;
    logic [AW-1:0]            mem_address;
    logic                     mem_read, mem_waitrequest;
    logic [NM*DW-1:0]         mem_readdata;
    logic                     mem_readdatavalid;
    logic                     dp_rst_n, clr_accum, start_compute;
    logic [NM-1:0][DW-1:0]    fifo_a_data;
    logic [NM-1:0]            fifo_a_wren, fifo_a_full;
    logic [DW-1:0]            fifo_b_data;
    logic                     fifo_b_wren, fifo_b_full, all_fifos_full, compute_done;
    logic [NM-1:0][RW-1:0]    mac_out, res_out;

    matvec_job_ctrl #(.DATA_WIDTH(DW), .NUM_MACS(NM), .VEC_LEN(VL), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .base_a(base_a), .base_b(base_b),
        .busy(busy), .done(done), .err(err),
        .mem_address(mem_address), .mem_read(mem_read), .mem_waitrequest(mem_waitrequest),
        .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid),
        .dp_rst_n(dp_rst_n), .clr_accum(clr_accum), .start_compute(start_compute),
        .fifo_a_data(fifo_a_data), .fifo_a_wren(fifo_a_wren), .fifo_a_full(fifo_a_full),
        .fifo_b_data(fifo_b_data), .fifo_b_wren(fifo_b_wren), .fifo_b_full(fifo_b_full),
        .all_fifos_full(all_fifos_full), .compute_done(compute_done),
        .mac_out(mac_out), .res_out(res_out)
    );

    typedef struct {
        logic [NM-1:0][RW-1:0] res;
        logic                  err;
        int                    writes;
        int                    dprst;
    } exp_t;

    exp_t                  sb[$];
    logic [NM*DW-1:0]      mem [logic [AW-1:0]];
    logic [NM-1:0][RW-1:0] last_res;
    int                    errors = 0;
    int                    checks = 0;
    int                    jobs_issued = 0;
    int                    stall_mode = 0;
    logic                  full_en = 1'b0;
    logic [AW-1:0]         full_addr = '0;
    int                    wr_cnt = 0;
    int                    dp_rst_cycles = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: res[i] = sum over k of A[i][k]*B[k], A column k at word ba+k, B in word bb.
    function automatic logic [NM-1:0][RW-1:0] ref_result(input logic [AW-1:0] ba, input logic [AW-1:0] bb);
        logic [NM-1:0][RW-1:0] r;
        logic [NM*DW-1:0]      bw, aw;
        int                    acc;
        bw = mem[bb];
        for (int i = 0; i < NM; i++) begin
            acc = 0;
            for (int k = 0; k < VL; k++) begin
                aw = mem[AW'(ba + k)];
                acc += int'(aw[i*DW +: DW]) * int'(bw[k*DW +: DW]);
            end
            r[i] = acc[RW-1:0];
        end
        return r;
    endfunction

    task automatic fill(input logic [AW-1:0] ba, input logic [AW-1:0] bb, input int kind);
        logic [NM*DW-1:0] w;
        w = '0;
        for (int k = 0; k < VL; k++) begin
            if (kind == 0) w[k*DW +: DW] = DW'(k + 1);
            else if (kind == 1) w[k*DW +: DW] = '1;
            else w[k*DW +: DW] = DW'($urandom);
        end
        mem[bb] = w;
        for (int k = 0; k < VL; k++) begin
            if (kind == 0) begin
                w = '0;
                w[k*DW +: DW] = 8'd1;
            end else if (kind == 1) begin
                w = '1;
            end else begin
                w = {$urandom, $urandom};
            end
            mem[AW'(ba + k)] = w;
        end
    endtask

    task automatic push_exp(input logic [NM-1:0][RW-1:0] r, input logic e, input int w);
        exp_t x;
        jobs_issued++;
        x.res = r; x.err = e; x.writes = w; x.dprst = jobs_issued;
        sb.push_back(x);
        last_res = r;
    endtask

    task automatic pulse_go(input logic [AW-1:0] ba, input logic [AW-1:0] bb);
        base_a = ba; base_b = bb; go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    task automatic wait_job();
        int n = 0;
        while (!done && n < 4000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("job_done_seen", done, 1'b1);
        @(posedge clk); #1;
        chk("busy_low_after", busy, 1'b0);
        chk("done_low_after", done, 1'b0);
    endtask

    task automatic run_job(input logic [AW-1:0] ba, input logic [AW-1:0] bb, input int kind);
        fill(ba, bb, kind);
        push_exp(ref_result(ba, bb), 1'b0, VL);
        pulse_go(ba, bb);
        wait_job();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_mem_read"}, mem_read, 1'b0);
        chk({tag, "_mem_address"}, mem_address, 32'd0);
        chk({tag, "_dp_rst_n"}, dp_rst_n, 1'b0);
        chk({tag, "_clr_start"}, {clr_accum, start_compute}, 2'b00);
        chk({tag, "_wren"}, {fifo_a_wren, fifo_b_wren}, '0);
        chk({tag, "_res_out"}, res_out, '0);
    endtask

    // Memory responder: programmable stall, 0..2 cycle read latency, stall-stability check.
    initial begin
        logic          req_seen, rsp_pend, full_hit;
        int            stall_left, rsp_cnt;
        logic [AW-1:0] req_addr;
        logic [NM*DW-1:0] rsp_data;
        req_seen = 0; rsp_pend = 0; full_hit = 0; stall_left = 0; rsp_cnt = 0;
        req_addr = '0; rsp_data = '0;
        mem_waitrequest = 0; mem_readdatavalid = 0; mem_readdata = '0; fifo_b_full = 0;
        forever begin
            @(posedge clk); #1;
            mem_readdatavalid = 1'b0;
            if (!rst_n) begin
                req_seen = 0; rsp_pend = 0; full_hit = 0; mem_waitrequest = 0;
            end else begin
                if (rsp_pend) begin
                    if (rsp_cnt == 0) begin
                        mem_readdata = rsp_data;
                        mem_readdatavalid = 1'b1;
                        rsp_pend = 0;
                    end else begin
                        rsp_cnt--;
                    end
                end
                if (mem_read) begin
                    if (!req_seen) begin
                        req_seen = 1;
                        req_addr = mem_address;
                        stall_left = (stall_mode == 1) ? 5 : int'($urandom_range(0, 2));
                    end else begin
                        chk("stall_addr_hold", mem_address, req_addr);
                    end
                    if (stall_left > 0) begin
                        mem_waitrequest = 1'b1;
                        stall_left--;
                    end else begin
                        mem_waitrequest = 1'b0;
                        rsp_pend = 1;
                        rsp_cnt = int'($urandom_range(0, 2));
                        rsp_data = mem.exists(req_addr) ? mem[req_addr] : '0;
                        req_seen = 0;
                        if (full_en && req_addr == full_addr) full_hit = 1;
                    end
                end else begin
                    if (req_seen) chk("stall_read_hold", mem_read, 1'b1);
                    req_seen = 0;
                    mem_waitrequest = 1'b0;
                end
                if (!full_en) full_hit = 0;
            end
            fifo_b_full = full_hit;
        end
    end

    // Datapath model: collects FIFO writes, computes MACs a few cycles after start.
    initial begin
        logic [NM-1:0][DW-1:0] a_store [VL];
        logic [DW-1:0]         b_store [VL];
        int                    cd_cnt, acc;
        cd_cnt = 0;
        fifo_a_full = '0; all_fifos_full = 0; compute_done = 0; mac_out = '0;
        forever begin
            @(posedge clk); #1;
            if (!dp_rst_n) begin
                if (busy) begin
                    dp_rst_cycles++;
                    chk("clr_with_dp_rst", clr_accum, 1'b1);
                end
                wr_cnt = 0; cd_cnt = 0; compute_done = 0; all_fifos_full = 0;
            end else begin
                all_fifos_full = (wr_cnt >= VL);
                if (fifo_b_wren || fifo_a_wren != '0)
                    chk("a_wren_all_lanes", fifo_a_wren, {NM{fifo_b_wren}});
                if (fifo_b_wren) begin
                    if (wr_cnt < VL) begin
                        a_store[wr_cnt] = fifo_a_data;
                        b_store[wr_cnt] = fifo_b_data;
                    end
                    wr_cnt++;
                end
                if (start_compute) begin
                    cd_cnt = 3;
                end else if (cd_cnt > 0) begin
                    cd_cnt--;
                    if (cd_cnt == 0) begin
                        for (int i = 0; i < NM; i++) begin
                            acc = 0;
                            for (int k = 0; k < VL; k++)
                                acc += int'(a_store[k][i]) * int'(b_store[k]);
                            mac_out[i] = acc[RW-1:0];
                        end
                        compute_done = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: pops one expectation per done pulse.
    initial begin
        logic prev_done;
        exp_t e;
        prev_done = 0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && done) begin
                chk("done_one_cycle", prev_done, 1'b0);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("res_out", res_out, e.res);
                    chk("err_at_done", err, e.err);
                    chk("fifo_writes", wr_cnt, e.writes);
                    chk("dp_rst_pulses", dp_rst_cycles, e.dprst);
                end
            end
            prev_done = rst_n ? done : 1'b0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NM-1:0][RW-1:0] r1, r2;
        logic [NM-1:0][RW-1:0] all_ff;
        int n;
        rst_n = 1'b0; go = 1'b0; base_a = '0; base_b = '0; last_res = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_dp_rst_n", dp_rst_n, 1'b1);

        // Identity A, B = 1..8
        run_job(32'h0000_0100, 32'h0000_0080, 0);
        for (int i = 0; i < NM; i++) chk("identity_lane", res_out[i], RW'(i + 1));

        // All 0xFF
        run_job(32'h0000_0200, 32'h0000_0180, 1);
        for (int i = 0; i < NM; i++) all_ff[i] = 24'h07F008;
        chk("all_ff_lanes", res_out, all_ff);
        chk("all_ff_no_err", err, 1'b0);

        // Long stalls on every read
        stall_mode = 1;
        run_job(32'h0000_0300, 32'h0000_0280, 0);
        stall_mode = 0;

        // Overflow at column 3: writes suppressed, err set, results untouched
        fill(32'h0000_0400, 32'h0000_0380, 2);
        full_addr = 32'h0000_0403; full_en = 1'b1;
        push_exp(last_res, 1'b1, 3);
        pulse_go(32'h0000_0400, 32'h0000_0380);
        wait_job();
        full_en = 1'b0;
        chk("err_sticky", err, 1'b1);
        run_job(32'h0000_0500, 32'h0000_0480, 2);
        chk("err_cleared", err, 1'b0);

        // Reset in the middle of column 4
        fill(32'h0000_0600, 32'h0000_0580, 2);
        jobs_issued++;
        pulse_go(32'h0000_0600, 32'h0000_0580);
        n = 0;
        while (!(mem_read && mem_address == 32'h0000_0604) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_reached_k4", mem_read && mem_address == 32'h0000_0604, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("abort");
        last_res = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_job(32'h0000_0700, 32'h0000_0680, 0);

        // go held through WAIT, then back-to-back second job
        fill(32'h0000_0800, 32'h0000_0780, 2);
        fill(32'h0000_0900, 32'h0000_0880, 2);
        r1 = ref_result(32'h0000_0800, 32'h0000_0780);
        r2 = ref_result(32'h0000_0900, 32'h0000_0880);
        push_exp(r1, 1'b0, VL);
        pulse_go(32'h0000_0800, 32'h0000_0780);
        n = 0;
        while (!start_compute && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_reached_wait", start_compute, 1'b1);
        base_a = 32'h0000_0900; base_b = 32'h0000_0880; go = 1'b1;
        push_exp(r2, 1'b0, VL);
        n = 0;
        while (busy && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_first_idle", busy, 1'b0);
        @(posedge clk); #1;
        go = 1'b0;
        chk("b2b_second_accepted", busy, 1'b1);
        wait_job();

        // Random jobs with random stalls
        for (int j = 0; j < 6; j++) begin
            stall_mode = int'($urandom_range(0, 1));
            run_job(32'h0001_0000 + AW'(j) * 32'h100, 32'h0001_0080 + AW'(j) * 32'h100, 2);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
